tb_txn_arbiter: RTL and testbench
=================================

Name: tb_txn_arbiter

Overview:
- Round-robin arbiter that shares the single DUT stimulus channel among NUM_REQ test-side requesters (sequence drivers).
- Sits between test-side requesters and the DUT-side interface, in the test-bench hook-up layer.
- Grants the channel for a whole transaction (burst terminated by a last beat), then re-arbitrates.
- A stall watchdog aborts a grant that stops making progress, so a hung requester or DUT cannot deadlock the bench.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 32, width of one data beat.
- TIMEOUT, 255, cycles with no accepted beat before the grant is aborted; 0 disables the watchdog.
- ID_W, $clog2(NUM_REQ), width of the grant and error IDs (derived; do not override).

Ports:
- tb_clk  in  1  bench clock; all logic is on the rising edge.
- tb_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_W  per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  per-requester last-beat-of-transaction flag.
- req_ready  out  NUM_REQ  per-requester beat accepted.
- dut_valid  out  1  beat valid towards the DUT.
- dut_data  out  DATA_W  beat data towards the DUT.
- dut_last  out  1  last beat of the transaction.
- dut_ready  in  1  DUT accepts the beat.
- grant_id  out  ID_W  current or most recent grantee.
- busy  out  1  a grant is active (state XFER).
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a grant.
- err_id  out  ID_W  requester aborted at the last timeout; holds its value until the next timeout.

Behaviour:
- Reset (asynchronous, tb_rst_n=0):
  - state=IDLE.
  - dut_valid=0, dut_last=0, dut_data=0, req_ready=0.
  - grant_id=0, busy=0, timeout_err=0, err_id=0.
  - Round-robin pointer last_gnt=NUM_REQ-1, so requester 0 has first priority.
  - Stall counter=0.
- States: IDLE, XFER, ABORT.
- IDLE:
  - All outputs idle.
  - If any req_valid is high, select the first set bit searching upward from last_gnt+1, modulo NUM_REQ.
  - Register that index in grant_id and go to XFER.
  - Arbitration latency: 1 cycle (req_valid seen at edge N → dut_valid may be high after edge N+1).
- XFER:
  - busy=1.
  - dut_valid = req_valid[grant_id], dut_data = req_data slice, dut_last = req_last[grant_id].
  - req_ready[grant_id] = dut_ready; all other req_ready = 0.
  - Paths from req_valid/dut_ready to the outputs are combinational.
  - A beat is accepted when dut_valid && dut_ready.
  - Accepted beat with dut_last=1: last_gnt <= grant_id, go to IDLE. There is no back-to-back grant in the same cycle; one idle cycle separates transactions.
  - Grantee dropping req_valid mid-burst: the grant is held (no preemption).
  - Requests from other requesters are ignored until the grant ends.
- Watchdog (TIMEOUT>0):
  - The stall counter increments every XFER cycle with no accepted beat and clears on any accepted beat or on leaving XFER.
  - When the counter equals TIMEOUT-1 and the beat is still not accepted, go to ABORT on the next edge.
  - Net effect: TIMEOUT consecutive non-accept cycles abort the grant.
- ABORT (one cycle):
  - dut_valid=0, req_ready=0, busy=0.
  - timeout_err=1 and err_id=grant_id, both registered on entry.
  - last_gnt <= grant_id, so the hung requester drops to lowest priority.
  - Next state IDLE.
- Simultaneous events: an accepted last beat in the same cycle the counter reaches its limit counts as completion, not timeout.
- Reset mid-burst: the burst is dropped silently and no timeout_err is raised. Requesters must restart their transactions.
- grant_id holds its value in IDLE and ABORT. It is valid for logging after the grant ends.

Test Plan:
- Single requester: req 2 sends a 3-beat burst, dut_ready=1 → grant_id=2 one cycle after req_valid; 3 beats pass in order with dut_last on beat 3; busy drops the next cycle.
- Round-robin fairness: all 4 requesters request continuous 1-beat transactions after reset → grant order 0,1,2,3,0,… with exactly one IDLE cycle between grants.
- Burst lock: req 1 is granted a 4-beat burst and req 0 raises valid mid-burst → req_ready[0] stays 0 until req 1's last beat; then req 2/3 (if requesting) precede 0 per the pointer.
- Backpressure: dut_ready toggles 1,0,0,1 during a burst → data stable and req_ready mirrors dut_ready; no timeout with TIMEOUT=255.
- Watchdog: TIMEOUT=8, req 3 is granted, dut_ready held at 0 → timeout_err pulses exactly once, 8 cycles after the first dut_valid, err_id=3; the next grant goes to a different pending requester.
- Async reset mid-burst: assert tb_rst_n low during beat 2 → all outputs return to reset values immediately, timeout_err stays 0, and requester 0 wins the first grant after release.

Source files
------------

// File: rtl/tb_txn_arbiter.sv
// Round-robin arbiter sharing one stimulus channel among NUM_REQ requesters.
// Grants last for a whole transaction; a stall watchdog aborts hung grants.
module tb_txn_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      tb_clk,
  input  logic                      tb_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      dut_valid,
  output logic [DATA_W-1:0]         dut_data,
  output logic                      dut_last,
  input  logic                      dut_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [ID_W-1:0]           err_id
);

  localparam int unsigned N     = NUM_REQ;
  localparam int          CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, XFER, ABORT} state_t;

  state_t           state;
  logic [ID_W-1:0]  last_gnt;
  logic [ID_W-1:0]  pick;
  logic [CNT_W-1:0] stall_cnt;
  logic             any_req;
  logic             accept;
  logic             stall_hit;

  assign any_req = |req_valid;
  assign busy    = (state == XFER);

  // Search upward from the requester after the last grantee, wrapping.
  always_comb begin
    int unsigned idx;
    logic        found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (int'(last_gnt) + i) % N;
      if (!found && req_valid[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    dut_valid = 1'b0;
    dut_data  = '0;
    dut_last  = 1'b0;
    req_ready = '0;
    if (busy) begin
      dut_valid           = req_valid[grant_id];
      dut_data            = req_data[int'(grant_id)*DATA_W +: DATA_W];
      dut_last            = req_last[grant_id];
      req_ready[grant_id] = dut_ready;
    end
  end

  assign accept    = dut_valid && dut_ready;
  assign stall_hit = (TIMEOUT > 0) && !accept && (stall_cnt == LIMIT);

  always_ff @(posedge tb_clk or negedge tb_rst_n) begin
    if (!tb_rst_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      last_gnt    <= ID_W'(NUM_REQ - 1);
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
      err_id      <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (any_req) begin
            grant_id <= pick;
            state    <= XFER;
          end
        end
        XFER: begin
          // Accepted beats win over the watchdog when both happen together.
          if (accept) begin
            stall_cnt <= '0;
            if (dut_last) begin
              last_gnt <= grant_id;
              state    <= IDLE;
            end
          end else if (stall_hit) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b1;
            err_id      <= grant_id;
            last_gnt    <= grant_id;
            state       <= ABORT;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        ABORT: begin
          stall_cnt <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_txn_arbiter.sv
// Scoreboard bench for tb_txn_arbiter: directed bursts, expected beats queued
// at issue time and checked by an independent monitor on the falling edge.
module tb_tb_txn_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [127:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        dut_valid;
  logic [31:0] dut_data;
  logic        dut_last;
  logic        dut_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  err_id;

  tb_txn_arbiter #(.NUM_REQ(4), .DATA_W(32), .TIMEOUT(8)) dut (
    .tb_clk     (clk),
    .tb_rst_n   (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .dut_valid  (dut_valid),
    .dut_data   (dut_data),
    .dut_last   (dut_last),
    .dut_ready  (dut_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_id     (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] d; logic l;} beat_t;
  typedef struct packed {logic [1:0] id; logic [31:0] d; logic l;} exp_t;

  beat_t      rq[4][$];
  exp_t       sb[$];
  logic [1:0] err_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_data[i*32 +: 32]  = rq[i][0].d;
        req_last[i]           = rq[i][0].l;
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*32 +: 32]  = '0;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  // Queue a beat on requester id and record the beat the DUT must deliver.
  task automatic load(input int id, input logic [31:0] d, input logic l, input logic expect_it);
    beat_t b;
    exp_t  e;
    b.d = d;
    b.l = l;
    rq[id].push_back(b);
    if (expect_it) begin
      e.id = 2'(id);
      e.d  = d;
      e.l  = l;
      sb.push_back(e);
    end
  endtask

  task automatic cycle();
    logic [3:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i]) void'(rq[i].pop_front());
    refresh();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() > 0 && n < max_cycles) begin
      cycle();
      n++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: actual %0d beats pending required 0", sb.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) rq[i].delete();
    refresh();
    #1;
    check("rst_dut_valid", 64'(dut_valid), 64'(0));
    check("rst_dut_last", 64'(dut_last), 64'(0));
    check("rst_dut_data", 64'(dut_data), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_timeout_err", 64'(timeout_err), 64'(0));
    check("rst_err_id", 64'(err_id), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every accepted beat and every timeout pulse is matched against the queues.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && dut_valid && dut_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: actual id %0d data %0h required none", grant_id, dut_data);
        end else begin
          e = sb.pop_front();
          check("beat_id", 64'(grant_id), 64'(e.id));
          check("beat_data", 64'(dut_data), 64'(e.d));
          check("beat_last", 64'(dut_last), 64'(e.l));
          check("beat_ready", 64'(req_ready), 64'(4'b0001 << e.id));
        end
      end
      if (timeout_err) begin
        if (err_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_timeout: actual err_id %0d required no pulse", err_id);
        end else begin
          check("err_id", 64'(err_id), 64'(err_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    dut_ready = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    do_reset();

    // Single requester, 3-beat burst from req 2
    dut_ready = 1'b1;
    load(2, 32'h2000_0001, 1'b0, 1'b1);
    load(2, 32'h2000_0002, 1'b0, 1'b1);
    load(2, 32'h2000_0003, 1'b1, 1'b1);
    refresh();
    #1 check("t1_idle_before_grant", 64'(busy), 64'(0));
    cycle();
    check("t1_grant_id", 64'(grant_id), 64'(2));
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_dut_valid", 64'(dut_valid), 64'(1));
    cycle();
    cycle();
    check("t1_busy_mid", 64'(busy), 64'(1));
    cycle();
    check("t1_busy_after", 64'(busy), 64'(0));
    check("t1_grant_hold", 64'(grant_id), 64'(2));

    // Round-robin fairness: two 1-beat transactions per requester
    do_reset();
    dut_ready = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        load(i, 32'h3000_0000 | 32'(k << 4) | 32'(i), 1'b1, 1'b1);
    refresh();
    for (int k = 1; k <= 16; k++) begin
      cycle();
      check("t2_busy", 64'(busy), 64'(k % 2));
      if (k % 2 == 1) check("t2_grant", 64'(grant_id), 64'(((k - 1) / 2) % 4));
    end

    // Burst lock: req 1 holds the channel; late requesters follow pointer order
    for (int j = 1; j <= 4; j++) load(1, 32'h4000_0000 | 32'(j), 1'(j == 4), 1'b1);
    refresh();
    cycle();
    check("t3_grant", 64'(grant_id), 64'(1));
    load(0, 32'h4000_0A00, 1'b1, 1'b0);
    load(2, 32'h4000_0C00, 1'b1, 1'b1);
    load(3, 32'h4000_0D00, 1'b1, 1'b1);
    sb.push_back('{id: 2'd0, d: 32'h4000_0A00, l: 1'b1});
    refresh();
    for (int j = 0; j < 4; j++) begin
      #1 check("t3_lock_ready", 64'(req_ready), 64'(4'b0010));
      cycle();
    end
    check("t3_idle_gap", 64'(busy), 64'(0));
    cycle();
    check("t3_next_grant", 64'(grant_id), 64'(2));
    drain(20);

    // Backpressure: dut_ready 1,0,0,1 during a 4-beat burst
    for (int j = 1; j <= 4; j++) load(2, 32'h5000_0000 | 32'(j), 1'(j == 4), 1'b1);
    refresh();
    cycle();
    check("t4_grant", 64'(grant_id), 64'(2));
    cycle();
    dut_ready = 1'b0;
    #1;
    check("t4_stall_ready", 64'(req_ready), 64'(0));
    check("t4_stall_data", 64'(dut_data), 64'(32'h5000_0002));
    cycle();
    check("t4_stall_data2", 64'(dut_data), 64'(32'h5000_0002));
    check("t4_stall_valid", 64'(dut_valid), 64'(1));
    cycle();
    dut_ready = 1'b1;
    #1 check("t4_ready_mirror", 64'(req_ready), 64'(4'b0100));
    drain(20);

    // Watchdog: req 3 stalls with dut_ready low for 8 cycles
    dut_ready = 1'b0;
    load(3, 32'h6000_0001, 1'b0, 1'b0);
    load(3, 32'h6000_0002, 1'b1, 1'b0);
    load(0, 32'h6000_0A00, 1'b1, 1'b1);
    load(1, 32'h6000_0B00, 1'b1, 1'b1);
    sb.push_back('{id: 2'd3, d: 32'h6000_0001, l: 1'b0});
    sb.push_back('{id: 2'd3, d: 32'h6000_0002, l: 1'b1});
    err_q.push_back(2'd3);
    refresh();
    cycle();
    check("t5_grant", 64'(grant_id), 64'(3));
    check("t5_first_valid", 64'(dut_valid), 64'(1));
    for (int j = 1; j <= 7; j++) begin
      cycle();
      check("t5_no_early_timeout", 64'(timeout_err), 64'(0));
      check("t5_still_busy", 64'(busy), 64'(1));
    end
    cycle();
    check("t5_timeout_pulse", 64'(timeout_err), 64'(1));
    check("t5_err_id", 64'(err_id), 64'(3));
    check("t5_abort_busy", 64'(busy), 64'(0));
    check("t5_abort_valid", 64'(dut_valid), 64'(0));
    dut_ready = 1'b1;
    cycle();
    check("t5_pulse_end", 64'(timeout_err), 64'(0));
    check("t5_err_hold", 64'(err_id), 64'(3));
    cycle();
    check("t5_next_grant", 64'(grant_id), 64'(0));
    drain(30);

    // Async reset during beat 2 of a burst from req 1
    dut_ready = 1'b1;
    load(1, 32'h7000_0001, 1'b0, 1'b1);
    load(1, 32'h7000_0002, 1'b0, 1'b0);
    load(1, 32'h7000_0003, 1'b1, 1'b0);
    refresh();
    cycle();
    check("t6_grant", 64'(grant_id), 64'(1));
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(dut_valid), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_grant", 64'(grant_id), 64'(0));
    check("t6_rst_ready", 64'(req_ready), 64'(0));
    check("t6_rst_data", 64'(dut_data), 64'(0));
    check("t6_rst_timeout", 64'(timeout_err), 64'(0));
    for (int i = 0; i < 4; i++) rq[i].delete();
    refresh();
    cycle();
    cycle();
    rst_n = 1'b1;
    load(1, 32'h7000_0101, 1'b1, 1'b0);
    load(2, 32'h7000_0201, 1'b1, 1'b0);
    load(0, 32'h7000_0001, 1'b1, 1'b1);
    sb.push_back('{id: 2'd1, d: 32'h7000_0101, l: 1'b1});
    sb.push_back('{id: 2'd2, d: 32'h7000_0201, l: 1'b1});
    refresh();
    cycle();
    check("t6_first_grant", 64'(grant_id), 64'(0));
    drain(20);

    check("final_sb_empty", 64'(sb.size()), 64'(0));
    check("final_err_q_empty", 64'(err_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
